// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave answering serial-flash READ (0x03) from an on-chip 32-bit word memory port.
// Latency: MOSI sampled 3 clk after SCK rise at pin, MISO updated <=3 clk after SCK fall; mem_req 1 clk after last address bit.
// Backpressure: none on SPI; a byte whose word has not been acked shifts 8'hFF and sets sticky underrun.
// Optional feature macro: FLASH_RESP_JEDEC_ID_EN enables opcode 0x9F returning JEDEC_ID.
module spi_flash_responder
`ifdef FLASH_RESP_JEDEC_ID_EN
#(
    parameter logic [23:0] JEDEC_ID = 24'hC22016
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        cmd_error,
    output logic        underrun
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA, IGNORE
`ifdef FLASH_RESP_JEDEC_ID_EN
        , ID
`endif
    } state_t;

    state_t      state;
    logic        sck_meta, sck_s, sck_d;
    logic        cs_meta, cs_s, cs_d;
    logic        mosi_meta, mosi_s;
    logic [4:0]  bit_cnt;
    logic [6:0]  cmd_sr;
    logic [16:0] addr_sr;
    logic [31:0] cur_word, nxt_word;
    logic        cur_vld, nxt_vld;
    logic [15:0] cur_waddr;
    logic [1:0]  byte_off;
    logic        started;
    logic [7:0]  shreg;

    logic        sck_rise, sck_fall, cs_fall;
    logic [7:0]  cmd_byte;
    logic [17:0] addr_full;
    logic [15:0] next_waddr;
    logic        ld_swap, ld_vld, ack_hit_cur, ack_hit_nxt;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
`ifdef FLASH_RESP_JEDEC_ID_EN
    logic [1:0]  id_idx;
    logic [7:0]  id_byte;
`endif

    // Two-flop synchronizers for the async SPI pins plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta  <= 1'b0; sck_s  <= 1'b0; sck_d <= 1'b0;
            cs_meta   <= 1'b1; cs_s   <= 1'b1; cs_d  <= 1'b1;
            mosi_meta <= 1'b0; mosi_s <= 1'b0;
        end else begin
            sck_meta  <= spi_clk;  sck_s  <= sck_meta; sck_d <= sck_s;
            cs_meta   <= spi_cs_n; cs_s   <= cs_meta;  cs_d  <= cs_s;
            mosi_meta <= spi_mosi; mosi_s <= mosi_meta;
        end
    end

    // Edge strobes, byte selection and ack steering; a byte at offset 0 after the first one comes from the next-word buffer.
    always_comb begin
        sck_rise    = sck_s && !sck_d;
        sck_fall    = !sck_s && sck_d;
        cs_fall     = !cs_s && cs_d;
        cmd_byte    = {cmd_sr, mosi_s};
        addr_full   = {addr_sr, mosi_s};
        next_waddr  = cur_waddr + 16'd1;
        ld_swap     = started && (byte_off == 2'd0);
        ld_word     = ld_swap ? nxt_word : cur_word;
        ld_vld      = ld_swap ? nxt_vld : cur_vld;
        ack_hit_cur = mem_req && mem_ack && (state == DATA) && (mem_addr == cur_waddr);
        ack_hit_nxt = mem_req && mem_ack && (state == DATA) && (mem_addr == next_waddr);
        case (byte_off)
            2'd0:    ld_byte = ld_word[31:24];
            2'd1:    ld_byte = ld_word[23:16];
            2'd2:    ld_byte = ld_word[15:8];
            default: ld_byte = ld_word[7:0];
        endcase
`ifdef FLASH_RESP_JEDEC_ID_EN
        case (id_idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'hFF;
        endcase
`endif
    end

    // Protocol FSM, shift registers, word buffers and memory request port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bit_cnt     <= 5'd0;
            cmd_sr      <= 7'd0;
            addr_sr     <= 17'd0;
            cur_word    <= 32'd0;
            nxt_word    <= 32'd0;
            cur_vld     <= 1'b0;
            nxt_vld     <= 1'b0;
            cur_waddr   <= 16'd0;
            byte_off    <= 2'd0;
            started     <= 1'b0;
            shreg       <= 8'hFF;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= 16'd0;
            cmd_error   <= 1'b0;
            underrun    <= 1'b0;
`ifdef FLASH_RESP_JEDEC_ID_EN
            id_idx      <= 2'd0;
`endif
        end else begin
            cmd_error   <= 1'b0;
            spi_miso_oe <= !cs_s;

            // One request in flight; acks for words no longer wanted are dropped by address mismatch.
            if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
                if (ack_hit_cur) begin
                    cur_word <= mem_rdata;
                    cur_vld  <= 1'b1;
                end else if (ack_hit_nxt) begin
                    nxt_word <= mem_rdata;
                    nxt_vld  <= 1'b1;
                end
            end else if (!mem_req && (state == DATA)) begin
                if (!cur_vld) begin
                    mem_req  <= 1'b1;
                    mem_addr <= cur_waddr;
                end else if (!nxt_vld) begin
                    mem_req  <= 1'b1;
                    mem_addr <= next_waddr;
                end
            end

            if ((state != IDLE) && cs_s) begin
                state    <= IDLE;
                busy     <= 1'b0;
                spi_miso <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state    <= CMD;
                        busy     <= 1'b1;
                        bit_cnt  <= 5'd0;
                        underrun <= 1'b0;
                        spi_miso <= 1'b1;
                    end
                    CMD: if (sck_rise) begin
                        cmd_sr  <= cmd_byte[6:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= 5'd0;
                            if (cmd_byte == 8'h03) begin
                                state <= ADDR;
`ifdef FLASH_RESP_JEDEC_ID_EN
                            end else if (cmd_byte == 8'h9F) begin
                                state  <= ID;
                                id_idx <= 2'd0;
`endif
                            end else begin
                                state     <= IGNORE;
                                cmd_error <= 1'b1;
                            end
                        end
                    end
                    ADDR: if (sck_rise) begin
                        addr_sr <= addr_full[16:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt   <= 5'd0;
                            state     <= DATA;
                            cur_waddr <= addr_full[17:2];
                            byte_off  <= addr_full[1:0];
                            started   <= 1'b0;
                            cur_vld   <= 1'b0;
                            nxt_vld   <= 1'b0;
                            if (!mem_req) begin
                                mem_req  <= 1'b1;
                                mem_addr <= addr_full[17:2];
                            end
                        end
                    end
                    DATA: begin
                        if (sck_rise)
                            bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
                        if (sck_fall) begin
                            if (bit_cnt[2:0] == 3'd0) begin
                                if (ld_vld) begin
                                    spi_miso <= ld_byte[7];
                                    shreg    <= {ld_byte[6:0], 1'b1};
                                end else begin
                                    spi_miso <= 1'b1;
                                    shreg    <= 8'hFF;
                                    underrun <= 1'b1;
                                end
                                byte_off <= byte_off + 2'd1;
                                started  <= 1'b1;
                                if (ld_swap) begin
                                    cur_waddr <= next_waddr;
                                    cur_word  <= ack_hit_nxt ? mem_rdata : nxt_word;
                                    cur_vld   <= nxt_vld | ack_hit_nxt;
                                    nxt_vld   <= 1'b0;
                                end
                            end else begin
                                spi_miso <= shreg[7];
                                shreg    <= {shreg[6:0], 1'b1};
                            end
                        end
                    end
`ifdef FLASH_RESP_JEDEC_ID_EN
                    ID: begin
                        if (sck_rise)
                            bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
                        if (sck_fall) begin
                            if (bit_cnt[2:0] == 3'd0) begin
                                spi_miso <= id_byte[7];
                                shreg    <= {id_byte[6:0], 1'b1};
                                if (id_idx != 2'd3)
                                    id_idx <= id_idx + 2'd1;
                            end else begin
                                spi_miso <= shreg[7];
                                shreg    <= {shreg[6:0], 1'b1};
                            end
                        end
                    end
`endif
                    IGNORE: spi_miso <= 1'b1;
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
